imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning instruction-memory word-address width (1024 words).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset; the block uses one clock, and reset is asynchronous and active-low.
REQ-004 SHALL have port load_start  input  1  single-cycle request to begin a program load.
REQ-005 SHALL have port word_cnt  input  ADDR_W+1  number of instruction words to load, sampled with load_start.
REQ-006 SHALL have port byte_valid  input  1  incoming program byte valid.
REQ-007 SHALL have port byte_data  input  8  incoming program byte.
REQ-008 SHALL have port byte_ready  output  1  loader can accept a byte.
REQ-009 SHALL have port imem_we  output  1  instruction-memory write enable.
REQ-010 SHALL have port imem_addr  output  32  instruction-memory byte address, word aligned (bits[1:0]=0).
REQ-011 SHALL have port imem_wdata  output  32  instruction word to write.
REQ-012 SHALL have port busy  output  1  high while in LOAD or CHECK.
REQ-013 SHALL have port cpu_run  output  1  high only in RUN; releases the pipeline.
REQ-014 SHALL have port load_err  output  1  checksum mismatch flag.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, CHECK, RUN; all outputs registered.
REQ-016 In IDLE or RUN, load_start=1 SHALL sample word_cnt, clear word index, byte index and load_err, and enter LOAD; if the sampled word_cnt=0, SHALL enter RUN directly.
REQ-017 word_cnt values above 2^ADDR_W SHALL be clamped to 2^ADDR_W.
REQ-018 load_start SHALL be ignored in LOAD and CHECK.
REQ-019 byte_ready SHALL be 1 in LOAD and CHECK, 0 otherwise; a byte transfers on a clk edge where byte_valid and byte_ready are both 1.
REQ-020 Bytes SHALL assemble little-endian: 1st byte to [7:0], 4th byte to [31:24].
REQ-021 The cycle after the 4th byte of a data word transfers, imem_we SHALL be 1 for exactly one cycle with imem_addr = word_index*4 and imem_wdata = assembled word; word_index then increments.
REQ-022 Byte acceptance SHALL not stall during the write cycle; back-to-back bytes SHALL be accepted every cycle.
REQ-023 After the write of word number word_cnt, the FSM SHALL enter CHECK when the checksum is compiled in, otherwise RUN.
REQ-024 cpu_run SHALL rise the cycle after entering RUN and fall the cycle after leaving RUN.
REQ-025 imem_addr SHALL never exceed (2^ADDR_W-1)*4; word_index SHALL not wrap within one load.

Reset
REQ-026 On rst_n=0, the block SHALL enter IDLE immediately: imem_we=0, imem_addr=0, imem_wdata=0, busy=0, cpu_run=0, load_err=0, byte_ready=0, and all counters=0.
REQ-027 Reset mid-LOAD SHALL abandon the load with no further writes; a partial word SHALL never be written.

Configuration
REQ-028 With macro IMEM_LOADER_CHECKSUM_EN defined, after the data words the loader SHALL receive one extra 4-byte word in CHECK (not written to memory) and compare it with the XOR of all data words: on a match it SHALL enter RUN, and on a mismatch it SHALL set load_err=1 and enter IDLE with cpu_run=0.
REQ-029 Without IMEM_LOADER_CHECKSUM_EN, the CHECK state SHALL be unreachable, load_err SHALL be tied to 0, and no checksum word SHALL be consumed.

Verification
REQ-030 Reset, then load_start with word_cnt=2 and bytes 13,00,00,00,93,00,10,00 -> writes (addr 0x0, 0x00000013) and (addr 0x4, 0x00100093), then cpu_run=1.
REQ-031 Byte_valid toggled 1/0 every cycle during a 1-word load of 0xDEADBEEF -> exactly one imem_we pulse, data 0xDEADBEEF.
REQ-032 word_cnt=0 in IDLE -> RUN with no imem_we; word_cnt=2047 -> exactly 1024 writes, last at addr 0xFFC.
REQ-033 rst_n low after 6 bytes of a 2-word load -> exactly one write (addr 0x0), all outputs 0 with no clock edge needed, and a subsequent fresh load starts at addr 0.
REQ-034 With IMEM_LOADER_CHECKSUM_EN, words 0x11111111 and 0x22222222 plus checksum 0x33333333 -> RUN; with checksum 0x33333334 -> load_err=1, IDLE, cpu_run=0.
REQ-035 load_start in RUN -> cpu_run falls, and a new load overwrites from addr 0x0.

Source files
------------

// File: rtl/imem_loader_if.sv
// Host-side program-load bus for imem_loader: byte stream in, instruction-memory
// write port and status flags out.
interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic              load_start;
  logic [ADDR_W:0]   word_cnt;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [31:0]       imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy;
  logic              cpu_run;
  logic              load_err;

  modport master (
    output load_start, word_cnt, byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata, busy, cpu_run, load_err
  );

  modport slave (
    input  load_start, word_cnt, byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata, busy, cpu_run, load_err
  );
endinterface

// File: rtl/imem_loader.sv
// Streams little-endian program bytes into instruction memory, then releases the CPU.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum word before RUN.
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  imem_loader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, CHECK, RUN} state_t;

  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE       = {{ADDR_W{1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic [ADDR_W:0] cnt_q;
  logic [ADDR_W:0] word_idx_q;
  logic [1:0]      byte_idx_q;
  logic [23:0]     asm_q;

  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            busy_q, busy_d;
  logic            run_q, run_d;
  logic            err_q, err_d;
  logic            ready_q, ready_d;

  logic            byte_fire;
  logic            word_done;
  logic            last_word;
  logic            start_ok;
  logic [31:0]     word_in;
  logic [ADDR_W:0] cnt_clamped;

  assign byte_fire   = bus.byte_valid && ready_q;
  assign word_done   = byte_fire && (byte_idx_q == 2'd3);
  assign word_in     = {bus.byte_data, asm_q};
  assign last_word   = ((word_idx_q + ONE) == cnt_q);
  assign start_ok    = bus.load_start && ((state_q == IDLE) || (state_q == RUN));
  assign cnt_clamped = (bus.word_cnt > MAX_WORDS) ? MAX_WORDS : bus.word_cnt;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] xor_q;
  logic        cs_match;
  assign cs_match = (word_in == xor_q);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path through this block infers a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE, RUN: begin
        if (bus.load_start) state_d = (cnt_clamped == '0) ? RUN : LOAD;
      end
      LOAD: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (word_done && last_word) state_d = CHECK;
`else
        if (word_done && last_word) state_d = RUN;
`endif
      end
      CHECK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (word_done) state_d = cs_match ? RUN : IDLE;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs.
  always_comb begin
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    ready_d = (state_d == LOAD) || (state_d == CHECK);
    busy_d  = ready_d;
    run_d   = (state_q == RUN);
    if (start_ok) err_d = 1'b0;
    if ((state_q == LOAD) && word_done) begin
      we_d    = 1'b1;
      addr_d  = 32'({word_idx_q[ADDR_W-1:0], 2'b00});
      wdata_d = word_in;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if ((state_q == CHECK) && word_done && !cs_match) err_d = 1'b1;
`else
    err_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      run_q   <= run_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  // Byte assembly and word counters; bytes shift in from the top so the first lands in [7:0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      asm_q      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q      <= '0;
`endif
    end else if (start_ok) begin
      cnt_q      <= cnt_clamped;
      word_idx_q <= '0;
      byte_idx_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q      <= '0;
`endif
    end else if (byte_fire) begin
      byte_idx_q <= byte_idx_q + 2'd1;
      asm_q      <= {bus.byte_data, asm_q[23:8]};
      if ((state_q == LOAD) && word_done) begin
        word_idx_q <= word_idx_q + ONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_q      <= xor_q ^ word_in;
`endif
      end
    end
  end

  assign bus.byte_ready = ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.busy       = busy_q;
  assign bus.cpu_run    = run_q;
  assign bus.load_err   = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random program images checked against a
// word-list model of the expected memory writes.
module tb_imem_loader;

  localparam int ADDR_W = 10;

  typedef logic [7:0]  byte_q_t[$];
  typedef logic [31:0] word_q_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mon_addr[$];
  logic [31:0] mon_data[$];

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] cs_bias = 32'd0;
`endif

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Every cycle with imem_we high is one recorded write.
  always @(negedge clk) begin
    if (bus.imem_we) begin
      mon_addr.push_back(bus.imem_addr);
      mon_data.push_back(bus.imem_wdata);
    end
  end

  task automatic apply_reset();
    bus.load_start = 1'b0;
    bus.word_cnt   = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic start_load(input logic [ADDR_W:0] cnt);
    bus.load_start = 1'b1;
    bus.word_cnt   = cnt;
    @(posedge clk);
    #1 bus.load_start = 1'b0;
  endtask

  // Program image as a byte stream, plus the XOR checksum word when enabled.
  task automatic make_bytes(input word_q_t words, output byte_q_t bytes);
    logic [31:0] cs;
    cs = '0;
    bytes.delete();
    foreach (words[i]) begin
      for (int b = 0; b < 4; b++) bytes.push_back(words[i][8*b +: 8]);
      cs = cs ^ words[i];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (words.size() > 0) begin
      cs = cs + cs_bias;
      for (int b = 0; b < 4; b++) bytes.push_back(cs[8*b +: 8]);
    end
`endif
  endtask

  // mode 0: valid every cycle, 1: valid on alternate cycles, 2: random gaps.
  task automatic send_bytes(input byte_q_t bytes, input int mode);
    int  i;
    int  c;
    bit  fire;
    i = 0;
    c = 0;
    while (i < bytes.size() && c < 50000) begin
      case (mode)
        0:       bus.byte_valid = 1'b1;
        1:       bus.byte_valid = (c % 2 == 0);
        default: bus.byte_valid = ($urandom_range(0, 3) != 0);
      endcase
      bus.byte_data = bytes[i];
      fire = bus.byte_valid && bus.byte_ready;
      @(posedge clk);
      #1;
      if (fire) i++;
      c++;
    end
    bus.byte_valid = 1'b0;
    if (i < bytes.size()) begin
      n_cmp++;
      n_bad++;
      $display("FAIL byte_stream_timeout: accepted %0d bytes, required %0d", i, bytes.size());
    end
  endtask

  task automatic do_load(input int cnt, input word_q_t words, input int mode);
    byte_q_t bytes;
    make_bytes(words, bytes);
    mon_addr.delete();
    mon_data.delete();
    start_load((ADDR_W+1)'(cnt));
    if (cnt > 0) send_bytes(bytes, mode);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if ({bus.imem_we, bus.busy, bus.cpu_run, bus.load_err, bus.byte_ready} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b, required 00000",
               {bus.imem_we, bus.busy, bus.cpu_run, bus.load_err, bus.byte_ready});
    end
    n_cmp++;
    if ({bus.imem_addr, bus.imem_wdata} !== 64'h0) begin
      n_bad++;
      $display("FAIL reset_bus: addr %h data %h, required 0", bus.imem_addr, bus.imem_wdata);
    end
  endtask

  task automatic test_basic();
    word_q_t w;
    w = '{32'h0000_0013, 32'h0010_0093};
    do_load(2, w, 0);
    n_cmp++;
    if (mon_addr.size() != 2) begin
      n_bad++;
      $display("FAIL basic_count: got %0d writes, required 2", mon_addr.size());
    end else begin
      n_cmp++;
      if (mon_addr[0] !== 32'h0 || mon_data[0] !== 32'h0000_0013) begin
        n_bad++;
        $display("FAIL basic_w0: got %h/%h, required 00000000/00000013", mon_addr[0], mon_data[0]);
      end
      n_cmp++;
      if (mon_addr[1] !== 32'h4 || mon_data[1] !== 32'h0010_0093) begin
        n_bad++;
        $display("FAIL basic_w1: got %h/%h, required 00000004/00100093", mon_addr[1], mon_data[1]);
      end
    end
    n_cmp++;
    if (bus.cpu_run !== 1'b1 || bus.busy !== 1'b0 || bus.byte_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_run: run/busy/ready %b%b%b, required 100",
               bus.cpu_run, bus.busy, bus.byte_ready);
    end
  endtask

  task automatic test_toggle();
    word_q_t w;
    w = '{32'hDEAD_BEEF};
    do_load(1, w, 1);
    n_cmp++;
    if (mon_addr.size() != 1 || mon_data[0] !== 32'hDEAD_BEEF || mon_addr[0] !== 32'h0) begin
      n_bad++;
      $display("FAIL toggle_write: %0d writes, first data %h, required 1 write of deadbeef at 0",
               mon_addr.size(), (mon_data.size() > 0) ? mon_data[0] : 32'hx);
    end
  endtask

  task automatic test_zero();
    word_q_t w;
    apply_reset();
    do_load(0, w, 0);
    n_cmp++;
    if (mon_addr.size() != 0 || bus.cpu_run !== 1'b1 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_words: %0d writes, run %b busy %b, required 0 writes run 1 busy 0",
               mon_addr.size(), bus.cpu_run, bus.busy);
    end
  endtask

  task automatic test_max();
    word_q_t w;
    int      bad;
    int      first;
    for (int i = 0; i < (1 << ADDR_W); i++) w.push_back($urandom);
    do_load(2047, w, 0);
    n_cmp++;
    if (mon_addr.size() != (1 << ADDR_W)) begin
      n_bad++;
      $display("FAIL max_count: got %0d writes, required %0d", mon_addr.size(), 1 << ADDR_W);
    end
    bad = 0;
    first = -1;
    for (int i = 0; i < mon_addr.size() && i < w.size(); i++)
      if (mon_addr[i] !== 32'(i * 4) || mon_data[i] !== w[i]) begin
        if (bad == 0) first = i;
        bad++;
      end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL max_contents: %0d wrong writes (first index %0d), required 0", bad, first);
    end
    n_cmp++;
    if (mon_addr.size() == 0 || mon_addr[mon_addr.size()-1] !== 32'hFFC || bus.cpu_run !== 1'b1) begin
      n_bad++;
      $display("FAIL max_last: last addr %h run %b, required 00000ffc run 1",
               (mon_addr.size() > 0) ? mon_addr[mon_addr.size()-1] : 32'hx, bus.cpu_run);
    end
  endtask

  task automatic test_reset_mid();
    byte_q_t b;
    word_q_t w;
    w = '{32'hA5A5_0001, 32'h5A5A_0002};
    make_bytes(w, b);
    while (b.size() > 6) void'(b.pop_back());
    mon_addr.delete();
    mon_data.delete();
    start_load(11'd2);
    send_bytes(b, 0);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.imem_we, bus.busy, bus.cpu_run, bus.load_err, bus.byte_ready} !== 5'b0 ||
        {bus.imem_addr, bus.imem_wdata} !== 64'h0) begin
      n_bad++;
      $display("FAIL midreset_outputs: flags %b addr %h data %h, required all 0",
               {bus.imem_we, bus.busy, bus.cpu_run, bus.load_err, bus.byte_ready},
               bus.imem_addr, bus.imem_wdata);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (mon_addr.size() != 1 || mon_addr[0] !== 32'h0 || mon_data[0] !== 32'hA5A5_0001) begin
      n_bad++;
      $display("FAIL midreset_writes: %0d writes, required 1 write of a5a50001 at 0", mon_addr.size());
    end
    w = '{$urandom};
    do_load(1, w, 2);
    n_cmp++;
    if (mon_addr.size() != 1 || mon_addr[0] !== 32'h0 || mon_data[0] !== w[0]) begin
      n_bad++;
      $display("FAIL midreset_fresh: %0d writes, first addr %h, required 1 write at 0 of %h",
               mon_addr.size(), (mon_addr.size() > 0) ? mon_addr[0] : 32'hx, w[0]);
    end
  endtask

  task automatic test_restart();
    word_q_t w;
    byte_q_t b;
    n_cmp++;
    if (bus.cpu_run !== 1'b1) begin
      n_bad++;
      $display("FAIL restart_pre: cpu_run %b, required 1", bus.cpu_run);
    end
    w = '{$urandom, $urandom};
    make_bytes(w, b);
    mon_addr.delete();
    mon_data.delete();
    start_load(11'd2);
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.cpu_run !== 1'b0 || bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL restart_drop: run %b busy %b, required run 0 busy 1", bus.cpu_run, bus.busy);
    end
    send_bytes(b, 0);
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (mon_addr.size() != 2 || mon_addr[0] !== 32'h0 || mon_data[0] !== w[0] ||
        mon_addr[1] !== 32'h4 || mon_data[1] !== w[1]) begin
      n_bad++;
      $display("FAIL restart_writes: %0d writes, first addr %h, required 2 writes from 0",
               mon_addr.size(), (mon_addr.size() > 0) ? mon_addr[0] : 32'hx);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      word_q_t w;
      int      n;
      int      bad;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) w.push_back($urandom);
      do_load(n, w, $urandom_range(0, 2));
      bad = (mon_addr.size() != n) ? 1 : 0;
      for (int i = 0; i < mon_addr.size() && i < n; i++)
        if (mon_addr[i] !== 32'(i * 4) || mon_data[i] !== w[i]) bad++;
      n_cmp++;
      if (bad != 0 || bus.cpu_run !== 1'b1 || bus.load_err !== 1'b0) begin
        n_bad++;
        $display("FAIL random_load_%0d: %0d writes (%0d wrong), run %b err %b, required %0d writes run 1 err 0",
                 it, mon_addr.size(), bad, bus.cpu_run, bus.load_err, n);
      end
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    word_q_t w;
    w = '{32'h1111_1111, 32'h2222_2222};
    cs_bias = 32'd0;
    do_load(2, w, 0);
    n_cmp++;
    if (bus.cpu_run !== 1'b1 || bus.load_err !== 1'b0 || mon_addr.size() != 2) begin
      n_bad++;
      $display("FAIL checksum_good: run %b err %b writes %0d, required run 1 err 0 writes 2",
               bus.cpu_run, bus.load_err, mon_addr.size());
    end
    cs_bias = 32'd1;
    do_load(2, w, 2);
    cs_bias = 32'd0;
    n_cmp++;
    if (bus.cpu_run !== 1'b0 || bus.load_err !== 1'b1 || bus.busy !== 1'b0 ||
        bus.byte_ready !== 1'b0 || mon_addr.size() != 2) begin
      n_bad++;
      $display("FAIL checksum_bad: run %b err %b busy %b writes %0d, required run 0 err 1 busy 0 writes 2",
               bus.cpu_run, bus.load_err, bus.busy, mon_addr.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_toggle();
    test_zero();
    test_max();
    test_reset_mid();
    test_restart();
    test_random();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
